// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: mux select codes, transmitter state
//                encoding, line levels and a state-to-select helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Select codes understood by uart_mux
    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    // Transmitter state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_PARITY  = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;

    // Line levels
    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

    // Mux select code driven while in a given state; IDLE shares the stop
    // code so the line rests high.
    function automatic logic [1:0] state_to_sel(input tx_state_e st);
        logic [1:0] sel;
        sel = SEL_STOP;
        case (st)
            S_START:  sel = SEL_START;
            S_DATA:   sel = SEL_DATA;
            S_PARITY: sel = SEL_PARITY;
            default:  sel = SEL_STOP;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl_if
//  Description : Host-side handshake plus mux-side bit outputs of the UART
//                transmit sequencer. The sequencer uses the slave modport.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 parity_en;
    logic                 parity_odd;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic [1:0]           select_bit;
    logic                 data_bit;
    logic                 parity_bit;
    logic                 start_bit;
    logic                 stop_bit;

    modport master (
        output tx_start, tx_data, parity_en, parity_odd,
        input  tx_ready, tx_busy, tx_done,
        input  select_bit, data_bit, parity_bit, start_bit, stop_bit
    );

    modport slave (
        input  tx_start, tx_data, parity_en, parity_odd,
        output tx_ready, tx_busy, tx_done,
        output select_bit, data_bit, parity_bit, start_bit, stop_bit
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_cnt
//  Description : Bit-period counter, 0..CLKS_PER_BIT-1 with rollover,
//                synchronous clear and a bit_end flag on the last count.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear_i,
    input  wire logic             en_i,
    output logic      [CNT_W-1:0] cnt_o,
    output logic                  bit_end_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count and wrap at the last cycle
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign bit_end_o = en_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_ctrl
//  Description : UART transmit sequencer. Accepts a byte on a start handshake
//                and steps uart_mux through start, data (LSB first), optional
//                parity and stop bit periods. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    uart_tx_ctrl_if.slave bus
);
    import uart_pkg::*;

    localparam int             CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [2:0]     IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_e            state_q,    state_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [2:0]           bit_idx_q,  bit_idx_d;
    logic                 par_en_q,   par_en_d;
    logic                 par_bit_q,  par_bit_d;
    logic                 data_bit_q, data_bit_d;
    logic [1:0]           sel_q,      sel_d;
    logic                 ready_q,    ready_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic [CNT_W-1:0]     baud_cnt;
    logic                 bit_end;
    logic                 cnt_clear;
    logic                 cnt_en;

    // Counter restarts on every state change so each state gets a full period
    assign cnt_en    = (state_q != S_IDLE);
    assign cnt_clear = (state_q == S_IDLE) || (state_d != state_q);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .en_i      (cnt_en),
        .cnt_o     (baud_cnt),
        .bit_end_o (bit_end)
    );

    // Next-state, datapath and registered-output next values
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;

        case (state_q)
            S_IDLE: begin
                if (bus.tx_start) begin
                    shift_d   = bus.tx_data;
                    par_en_d  = bus.parity_en;
                    par_bit_d = (^bus.tx_data) ^ bus.parity_odd;
                    bit_idx_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the next state so they change on the same edge
        sel_d      = state_to_sel(state_d);
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
        data_bit_d = (state_d == S_DATA) ? shift_d[0] : 1'b0;
        // One cycle early so the registered pulse lands on the last STOP cycle
        done_d     = (state_q == S_STOP) && (baud_cnt == CNT_PRE_LAST);
    end

    // State, holding registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            data_bit_q <= 1'b0;
            sel_q      <= SEL_STOP;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            data_bit_q <= data_bit_d;
            sel_q      <= sel_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_ready   = ready_q;
    assign bus.tx_busy    = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.select_bit = sel_q;
    assign bus.data_bit   = data_bit_q;
    assign bus.parity_bit = par_bit_q;
    assign bus.start_bit  = START_LEVEL;
    assign bus.stop_bit   = LINE_IDLE;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_ctrl
//  Description : Directed self-checking bench for uart_tx_ctrl with a
//                behavioural uart_mux on the outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_tx_ctrl_if #(.DATA_BITS(8)) bus ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (N),
        .DATA_BITS    (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial line as uart_mux would produce it
    function automatic logic mux_line();
        logic l;
        case (bus.select_bit)
            2'b00:   l = bus.start_bit;
            2'b01:   l = bus.data_bit;
            2'b10:   l = bus.parity_bit;
            default: l = bus.stop_bit;
        endcase
        return l;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " ready"}, 32'(bus.tx_ready), 32'd1);
        check({tag, " busy"},  32'(bus.tx_busy),  32'd0);
        check({tag, " done"},  32'(bus.tx_done),  32'd0);
        check({tag, " sel"},   32'(bus.select_bit), 32'd3);
        check({tag, " line"},  32'(mux_line()), 32'd1);
    endtask

    // Send one frame starting from an IDLE cycle and check every cycle of it.
    // exp_bits[p] is the hand-computed line level of bit period p.
    task automatic run_frame(input string tag, input logic [7:0] data, input logic pen,
                             input logic podd, input logic hold, input int corrupt_at,
                             input logic [10:0] exp_bits);
        int         len;
        int         p;
        logic [1:0] exp_sel;
        len = (pen ? 11 : 10) * N;
        bus.tx_data    = data;
        bus.parity_en  = pen;
        bus.parity_odd = podd;
        bus.tx_start   = 1'b1;
        check({tag, " accept ready"}, 32'(bus.tx_ready), 32'd1);
        for (int c = 1; c <= len; c++) begin
            tick();
            if (!hold) bus.tx_start = 1'b0;
            if (c == corrupt_at) begin
                bus.tx_data    = 8'h00;
                bus.parity_en  = ~pen;
                bus.parity_odd = ~podd;
            end
            p = (c - 1) / N;
            if (p == 0)               exp_sel = 2'b00;
            else if (p <= 8)          exp_sel = 2'b01;
            else if (p == 9 && pen)   exp_sel = 2'b10;
            else                      exp_sel = 2'b11;
            check($sformatf("%s c%0d line", tag, c), 32'(mux_line()), 32'(exp_bits[p]));
            check($sformatf("%s c%0d sel", tag, c),  32'(bus.select_bit), 32'(exp_sel));
            check($sformatf("%s c%0d done", tag, c), 32'(bus.tx_done), 32'(c == len));
            check($sformatf("%s c%0d busy", tag, c), 32'(bus.tx_busy), 32'd1);
            check($sformatf("%s c%0d ready", tag, c), 32'(bus.tx_ready), 32'd0);
        end
        tick();
        check_idle({tag, " gap"});
    endtask

    initial begin
        rst            = 1'b1;
        bus.tx_start   = 1'b0;
        bus.tx_data    = 8'h00;
        bus.parity_en  = 1'b0;
        bus.parity_odd = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check_idle("reset");
        check("reset data_bit",   32'(bus.data_bit),   32'd0);
        check("reset parity_bit", 32'(bus.parity_bit), 32'd0);
        check("start_bit const",  32'(bus.start_bit),  32'd0);
        check("stop_bit const",   32'(bus.stop_bit),   32'd1);
        tick();
        check_idle("idle hold");

        // 0xA5 even parity: line 0,1,0,1,0,0,1,0,1,0,1
        run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 0, 11'b1_0_10100101_0);
        // 0xA5 odd parity: parity period 1
        run_frame("a5_odd",  8'hA5, 1'b1, 1'b1, 1'b0, 0, 11'b1_1_10100101_0);
        // 0x00 no parity: 40-cycle frame
        run_frame("zero_np", 8'h00, 1'b0, 1'b0, 1'b0, 0, 11'b1_1_00000000_0);

        // tx_start held high: 0x3C (even parity 0) then 0xFF (odd parity 1);
        // inputs disturbed mid-frame must not reach the frame in flight
        run_frame("b2b_3c",  8'h3C, 1'b1, 1'b0, 1'b1, 8, 11'b1_0_00111100_0);
        run_frame("b2b_ff",  8'hFF, 1'b1, 1'b1, 1'b1, 0, 11'b1_1_11111111_0);
        bus.tx_start = 1'b0;
        tick();
        check_idle("b2b end");

        // Reset during DATA bit 3 of a 0x55 frame
        bus.tx_data   = 8'h55;
        bus.parity_en = 1'b0;
        bus.tx_start  = 1'b1;
        tick();
        bus.tx_start  = 1'b0;
        repeat (17) tick();
        check("abort pre sel", 32'(bus.select_bit), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("abort");
        check("abort parity_bit", 32'(bus.parity_bit), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("abort after %0d done", i), 32'(bus.tx_done), 32'd0);
            check($sformatf("abort after %0d sel", i),  32'(bus.select_bit), 32'd3);
        end
        // 0x81 even parity (two ones): parity 0
        run_frame("post_rst_81", 8'h81, 1'b1, 1'b0, 1'b0, 0, 11'b1_0_10000001_0);

        // 0xF0 with inputs changed two cycles after acceptance
        run_frame("f0_change", 8'hF0, 1'b0, 1'b0, 1'b0, 2, 11'b1_1_11110000_0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
